// File: rtl/imem_loader.sv
// imem_loader: packs a big-endian byte stream into 32-bit words and writes
// them to consecutive instruction RAM slots, starting at a programmable base.
module imem_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] IDX_ONE = 1;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic [ADDR_W:0]     widx_q, widx_d;
    logic [1:0]          bcnt_q, bcnt_d;
    logic [23:0]         asm_q, asm_d;      // first three bytes of the word
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   chk_q, chk_d;
    logic                error_q, error_d;

    // State and datapath registers; reset drops straight back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            cnt_q   <= '0;
            widx_q  <= '0;
            bcnt_q  <= '0;
            asm_q   <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            chk_q   <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            widx_q  <= widx_d;
            bcnt_q  <= bcnt_d;
            asm_q   <= asm_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            chk_q   <= chk_d;
            error_q <= error_d;
        end
    end

    // Next-state logic. The full word and its address are registered on the
    // 4th byte so WRITE drives RAM purely from flops, and they hold afterwards.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        widx_d  = widx_q;
        bcnt_d  = bcnt_q;
        asm_d   = asm_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        chk_d   = chk_q;
        error_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                // abort outranks start in the same cycle
                if (start && !abort) begin
                    if (word_count == '0) begin
                        error_d = 1'b1;
                    end else begin
                        base_d  = base_addr;
                        cnt_d   = word_count;
                        widx_d  = '0;
                        bcnt_d  = '0;
                        asm_d   = '0;
                        chk_d   = '0;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (abort) begin
                    // partial word is thrown away
                    bcnt_d  = '0;
                    asm_d   = '0;
                    state_d = S_IDLE;
                end else if (in_valid) begin
                    asm_d  = {asm_q[15:0], in_data};
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        wdata_d = {asm_q, in_data};
                        waddr_d = base_q + widx_q[ADDR_W-1:0];
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                // the write happens this cycle regardless of abort, so it
                // always counts toward the checksum
                chk_d  = chk_q ^ wdata_q;
                widx_d = widx_q + IDX_ONE;
                bcnt_d = '0;
                if (abort) begin
                    asm_d   = '0;
                    state_d = S_IDLE;
                end else if (widx_q + IDX_ONE == cnt_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs come from flops or a decode of the state register only.
    assign in_ready = (state_q == S_LOAD);
    assign we       = (state_q == S_WRITE);
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign error    = error_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;
    assign checksum = chk_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized loads checked against a list-of-writes model.
module tb_imem_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [7:0]  base_addr;
    logic [8:0]  word_count;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        we;
    logic [7:0]  waddr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] checksum;

    imem_loader #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .base_addr(base_addr), .word_count(word_count),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .we(we), .waddr(waddr), .wdata(wdata), .busy(busy), .done(done),
        .error(error), .checksum(checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // observed RAM writes and pulses
    logic [7:0]  wa_q[$];
    logic [31:0] wd_q[$];
    int n_done = 0;
    int n_err  = 0;
    int last_we_cyc = 0;
    int done_cyc = 0;

    // stimulus / expectation
    logic [31:0] ew[$];
    logic [7:0]  tx_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: record every write; a write cycle must never accept a byte.
    always @(negedge clk) begin
        if (rst_n) begin
            if (we) begin
                wa_q.push_back(waddr);
                wd_q.push_back(wdata);
                last_we_cyc = cyc;
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL in_ready_on_write: got %b want 0", in_ready);
                end
            end
            if (done === 1'b1) begin
                n_done++;
                done_cyc = cyc;
            end
            if (error === 1'b1) n_err++;
        end
    end

    task automatic clear_obs();
        wa_q.delete(); wd_q.delete();
        n_done = 0; n_err = 0;
    endtask

    task automatic words_to_bytes();
        tx_q.delete();
        foreach (ew[i]) begin
            logic [31:0] w;
            w = ew[i];
            tx_q.push_back(w[31:24]); tx_q.push_back(w[23:16]);
            tx_q.push_back(w[15:8]);  tx_q.push_back(w[7:0]);
        end
    endtask

    task automatic do_start(input logic [7:0] b, input logic [8:0] c);
        start = 1'b1; base_addr = b; word_count = c;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Send tx_q[lo..hi-1]; optionally idles in_valid for 1..3 cycles.
    task automatic send_bytes(input int lo, input int hi, input int stall_pct);
        for (int i = lo; i < hi; i++) begin
            bit acc;
            int g;
            if ($urandom_range(99) < stall_pct) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = tx_q[i];
            acc = 1'b0;
            g = 0;
            while (!acc && g < 200) begin
                acc = in_ready;
                @(negedge clk);
                g++;
            end
            if (!acc) begin
                checks++; errors++;
                $display("FAIL byte_accept: byte %0d not accepted within 200 cycles", i);
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
    endtask

    // Wait for done then compare observed writes against the model.
    task automatic check_load(input string nm, input int base);
        int g;
        logic [31:0] xs;
        g = 0;
        while (done !== 1'b1 && g < 50) begin @(negedge clk); g++; end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s_done_timeout: done never seen", nm);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_after: got %b want 0", nm, busy); end
        checks++;
        if (n_done != 1) begin errors++; $display("FAIL %s_done_count: got %0d want 1", nm, n_done); end
        checks++;
        if (n_err != 0) begin errors++; $display("FAIL %s_error_count: got %0d want 0", nm, n_err); end
        checks++;
        if (done_cyc != last_we_cyc + 1) begin
            errors++;
            $display("FAIL %s_done_timing: done cyc %0d last write cyc %0d", nm, done_cyc, last_we_cyc);
        end
        checks++;
        if (wa_q.size() != ew.size()) begin
            errors++;
            $display("FAIL %s_write_count: got %0d want %0d", nm, wa_q.size(), ew.size());
        end else begin
            int bad;
            bad = 0;
            foreach (ew[i]) begin
                if (bad < 4 && (wa_q[i] !== 8'((base + i) % 256) || wd_q[i] !== ew[i])) begin
                    bad++;
                    checks++; errors++;
                    $display("FAIL %s_write%0d: got %h@%h want %h@%h", nm, i,
                             wd_q[i], wa_q[i], ew[i], 8'((base + i) % 256));
                end
            end
        end
        xs = '0;
        foreach (ew[i]) xs ^= ew[i];
        checks++;
        if (checksum !== xs) begin
            errors++;
            $display("FAIL %s_checksum: got %h want %h", nm, checksum, xs);
        end
    endtask

    task automatic run_load(input string nm, input int base, input int cnt, input int stall_pct);
        clear_obs();
        words_to_bytes();
        do_start(8'(base), 9'(cnt));
        send_bytes(0, tx_q.size(), stall_pct);
        check_load(nm, base);
    endtask

    task automatic random_words(input int n);
        ew.delete();
        for (int i = 0; i < n; i++) ew.push_back($urandom());
    endtask

    task automatic test_reset();
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        checks++; if (we !== 1'b0)       begin errors++; $display("FAIL rst_we: got %b want 0", we); end
        checks++; if (done !== 1'b0 || error !== 1'b0) begin
            errors++; $display("FAIL rst_pulses: done %b error %b want 0 0", done, error);
        end
        checks++; if (waddr !== 8'h00 || wdata !== 32'h0 || checksum !== 32'h0) begin
            errors++; $display("FAIL rst_data: waddr %h wdata %h chk %h want zeros", waddr, wdata, checksum);
        end
    endtask

    task automatic test_basic();
        ew.delete();
        ew.push_back(32'h20080005);
        ew.push_back(32'h01090007);
        run_load("basic", 8'h10, 2, 0);
        checks++;
        if (checksum !== 32'h21010002) begin
            errors++; $display("FAIL basic_chk_const: got %h want 21010002", checksum);
        end
        // idle hold: last address/data stay, no write enable
        repeat (3) @(negedge clk);
        checks++;
        if (we !== 1'b0 || waddr !== 8'h11 || wdata !== 32'h01090007) begin
            errors++; $display("FAIL idle_hold: we %b waddr %h wdata %h want 0 11 01090007", we, waddr, wdata);
        end
    endtask

    task automatic test_stall();
        random_words(5);
        run_load("stall", $urandom_range(0, 255), 5, 40);
    endtask

    task automatic test_wrap();
        ew.delete();
        for (int i = 0; i < 4; i++) ew.push_back(32'hAAAA0000 + 32'(i));
        run_load("wrap", 8'hFE, 4, 10);
    endtask

    task automatic test_zero_count();
        clear_obs();
        do_start(8'h33, 9'd0);
        checks++;
        if (error !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL zero_err: error %b busy %b want 1 0", error, busy);
        end
        @(negedge clk);
        checks++;
        if (error !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL zero_err_pulse: error %b busy %b want 0 0", error, busy);
        end
    endtask

    task automatic test_start_busy();
        random_words(2);
        clear_obs();
        words_to_bytes();
        do_start(8'h20, 9'd2);
        send_bytes(0, 4, 0);
        start = 1'b1; base_addr = 8'h80; word_count = 9'd1;
        @(negedge clk);
        start = 1'b0;
        send_bytes(4, 8, 0);
        check_load("busy_start", 8'h20);
    endtask

    task automatic test_abort();
        logic [31:0] w0;
        random_words(3);
        w0 = ew[0];
        clear_obs();
        words_to_bytes();
        do_start(8'h40, 9'd3);
        send_bytes(0, 6, 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL abort_idle: busy %b in_ready %b want 0 0", busy, in_ready);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (wa_q.size() != 1 || n_done != 0) begin
            errors++; $display("FAIL abort_writes: writes %0d done %0d want 1 0", wa_q.size(), n_done);
        end
        checks++;
        if (checksum !== w0) begin
            errors++; $display("FAIL abort_chk: got %h want %h", checksum, w0);
        end
        random_words(1);
        run_load("after_abort", 8'h00, 1, 0);
    endtask

    task automatic test_async_reset();
        random_words(3);
        clear_obs();
        words_to_bytes();
        do_start(8'h90, 9'd3);
        send_bytes(0, 6, 0);
        checks++;
        if (checksum !== ew[0]) begin
            errors++; $display("FAIL areset_pre_chk: got %h want %h", checksum, ew[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || we !== 1'b0) begin
            errors++; $display("FAIL areset_immediate: busy %b in_ready %b we %b want 0 0 0", busy, in_ready, we);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || checksum !== 32'h0) begin
            errors++; $display("FAIL areset_after: busy %b chk %h want 0 0", busy, checksum);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) begin
            int n;
            n = $urandom_range(1, 6);
            random_words(n);
            run_load("b2b", $urandom_range(0, 255), n, 20);
        end
    endtask

    task automatic test_full();
        random_words(256);
        run_load("full", $urandom_range(0, 255), 256, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; base_addr = '0;
        word_count = '0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_stall();
        test_wrap();
        test_zero_count();
        test_start_busy();
        test_abort();
        test_async_reset();
        test_back_to_back();
        test_full();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
